// File: rtl/fir_hls_div_pkg.sv
// ============================================================================
// Module : fir_hls_div_pkg
// Brief  : Shared widths, FSM state codes, latency and saturation limits for
//          the sequential signed divider fir_hls_sdiv_31s_16s_seq.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fir_hls_div_pkg;

  // Default operand widths (dividend, divisor/remainder, quotient)
  localparam int DIN0_W = 31;
  localparam int DIN1_W = 16;
  localparam int DOUT_W = 16;

  // Accept edge to out_valid, in clock cycles
  localparam int LATENCY = DIN0_W + 1;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_FIX  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Quotient saturation limits (two's complement bit patterns)
  localparam logic [DOUT_W-1:0] QMAX = {1'b0, {(DOUT_W-1){1'b1}}};
  localparam logic [DOUT_W-1:0] QMIN = {1'b1, {(DOUT_W-1){1'b0}}};

endpackage

`default_nettype wire

// File: rtl/fir_hls_div_step.sv
// ============================================================================
// Module : fir_hls_div_step
// Brief  : One combinational restoring-division iteration. The caller has
//          already shifted the next dividend bit into the partial remainder;
//          this stage compares against the divisor magnitude and subtracts
//          when possible.
// Ports  : rem_shift_i  shifted partial remainder (W+1 bits)
//          dvsr_i       divisor magnitude (W bits, unsigned)
//          rem_next_o   partial remainder after the trial subtraction
//          qbit_o       quotient bit produced by this iteration
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_hls_div_step #(
  parameter int W = 16
) (
  input  logic [W:0]   rem_shift_i,
  input  logic [W-1:0] dvsr_i,
  output logic [W:0]   rem_next_o,
  output logic         qbit_o
);

  logic [W:0] w_dvsr_ext;
  logic [W:0] w_diff;

  assign w_dvsr_ext = {1'b0, dvsr_i};
  assign w_diff     = rem_shift_i - w_dvsr_ext;
  assign qbit_o     = (rem_shift_i >= w_dvsr_ext);
  assign rem_next_o = qbit_o ? w_diff : rem_shift_i;

endmodule

`default_nettype wire

// File: rtl/fir_hls_sdiv_31s_16s_seq.sv
// ============================================================================
// Module : fir_hls_sdiv_31s_16s_seq
// Brief  : Sequential signed divider, 31-bit dividend by 16-bit divisor.
//          Restoring radix-2, one quotient bit per cycle on magnitudes, then a
//          sign-fix / saturation cycle. C truncation semantics (q=a/b, r=a%b),
//          quotient saturated to 16 bits afterwards.
// Ports  : ap_clk, ap_rst_n     clock, asynchronous active-low reset
//          in_valid/in_ready    operand handshake (din0 dividend, din1 divisor)
//          out_valid/out_ready  result handshake
//          dout                 saturated signed quotient
//          rem                  signed remainder (sign of dividend)
//          ovf                  quotient saturated or divide by zero
//          dbz                  divisor was zero
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fir_hls_sdiv_31s_16s_seq
  import fir_hls_div_pkg::*;
#(
  parameter int din0_WIDTH = DIN0_W,
  parameter int din1_WIDTH = DIN1_W,
  parameter int dout_WIDTH = DOUT_W
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  ovf,
  output logic                  dbz
);

  localparam int D  = din0_WIDTH;
  localparam int W  = din1_WIDTH;
  localparam int CW = $clog2(D);
  // One extra bit so a magnitude of 2^(D-1) keeps a positive signed meaning
  localparam int QW = D + 1;

  localparam logic [QW-1:0] c_POS_LIM = QW'(QMAX);
  localparam logic [QW-1:0] c_NEG_LIM = QW'(QMAX) + QW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  // Holds |dividend| at accept; bits shift out the top as quotient bits
  // shift in the bottom, so it ends up holding |quotient|.
  logic [D-1:0]  dvd_q,   dvd_d;
  logic [W-1:0]  dvsr_q,  dvsr_d;
  logic [W:0]    prem_q,  prem_d;
  logic          sa_q,    sa_d;
  logic          sb_q,    sb_d;
  logic [W-1:0]  dlo_q,   dlo_d;   // raw dividend low bits, divide-by-zero rem
  logic [dout_WIDTH-1:0] dout_q, dout_d;
  logic [W-1:0]  rem_q,   rem_d;
  logic          ovf_q,   ovf_d;
  logic          dbz_q,   dbz_d;

  // Single restoring iteration, reused every CALC cycle
  logic [W:0] w_rem_shift;
  logic [W:0] w_rem_next;
  logic       w_qbit;

  assign w_rem_shift = {prem_q[W-1:0], dvd_q[D-1]};

  fir_hls_div_step #(
    .W (W)
  ) u_step (
    .rem_shift_i (w_rem_shift),
    .dvsr_i      (dvsr_q),
    .rem_next_o  (w_rem_next),
    .qbit_o      (w_qbit)
  );

  // Sign fix and saturation of the finished magnitudes
  logic          w_qneg;
  logic [QW-1:0] w_qmag;
  logic [QW-1:0] w_qs;
  logic          w_pos_ovf;
  logic          w_neg_ovf;
  logic [W-1:0]  w_rmag;
  logic [W-1:0]  w_rs;
  logic          w_dbz;

  assign w_qneg    = sa_q ^ sb_q;
  assign w_qmag    = {1'b0, dvd_q};
  assign w_qs      = w_qneg ? -w_qmag : w_qmag;
  assign w_pos_ovf = !w_qneg && (w_qmag > c_POS_LIM);
  assign w_neg_ovf = w_qneg && (w_qmag > c_NEG_LIM);
  assign w_rmag    = prem_q[W-1:0];
  assign w_rs      = sa_q ? -w_rmag : w_rmag;
  assign w_dbz     = (dvsr_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvsr_d  = dvsr_q;
    prem_d  = prem_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dlo_d   = dlo_q;
    dout_d  = dout_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Unary minus keeps the operand width; -(-2^(N-1)) yields the
          // bit pattern 2^(N-1), which is the correct unsigned magnitude.
          dvd_d   = din0[D-1] ? -din0 : din0;
          dvsr_d  = din1[W-1] ? -din1 : din1;
          sa_d    = din0[D-1];
          sb_d    = din1[W-1];
          dlo_d   = din0[W-1:0];
          prem_d  = '0;
          cnt_d   = CW'(D - 1);
          state_d = ST_CALC;
        end
      end

      ST_CALC: begin
        prem_d = w_rem_next;
        dvd_d  = {dvd_q[D-2:0], w_qbit};
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_FIX: begin
        if (w_dbz) begin
          dout_d = sa_q ? QMIN : QMAX;
          rem_d  = dlo_q;
          ovf_d  = 1'b1;
          dbz_d  = 1'b1;
        end else begin
          if (w_pos_ovf) begin
            dout_d = QMAX;
          end else if (w_neg_ovf) begin
            dout_d = QMIN;
          end else begin
            dout_d = w_qs[dout_WIDTH-1:0];
          end
          rem_d = w_rs;
          ovf_d = w_pos_ovf | w_neg_ovf;
          dbz_d = 1'b0;
        end
        state_d = ST_DONE;
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvsr_q  <= '0;
      prem_q  <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dlo_q   <= '0;
      dout_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvsr_q  <= dvsr_d;
      prem_q  <= prem_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dlo_q   <= dlo_d;
      dout_q  <= dout_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign dout      = dout_q;
  assign rem       = rem_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_hls_sdiv_31s_16s_seq.sv
// ============================================================================
// Module : tb_fir_hls_sdiv_31s_16s_seq
// Brief  : Self-checking bench for fir_hls_sdiv_31s_16s_seq. Expected results
//          come from C-style integer division on 64-bit values followed by
//          saturation to 16 bits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fir_hls_sdiv_31s_16s_seq;

  logic        ap_clk    = 1'b0;
  logic        ap_rst_n  = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [30:0] din0      = '0;
  logic [15:0] din1      = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] dout;
  logic [15:0] rem;
  logic        ovf;
  logic        dbz;

  int total = 0;
  int bad   = 0;

  fir_hls_sdiv_31s_16s_seq dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .rem       (rem),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // C semantics on wide integers, then saturation
  task automatic model(input logic [30:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r,
                       output logic ov, output logic dz);
    longint la, lb, lq, lr;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    if (lb == 0) begin
      dz = 1'b1;
      ov = 1'b1;
      q  = (la >= 0) ? 16'h7FFF : 16'h8000;
      r  = a[15:0];
    end else begin
      dz = 1'b0;
      lq = la / lb;
      lr = la % lb;
      if (lq > 32767) begin
        q = 16'h7FFF; ov = 1'b1;
      end else if (lq < -32768) begin
        q = 16'h8000; ov = 1'b1;
      end else begin
        q = lq[15:0]; ov = 1'b0;
      end
      r = lr[15:0];
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge ap_clk); #1;
      n++;
    end
    check({tag, ":ready"}, 32'(in_ready), 32'd1);
  endtask

  // Full transaction: accept, latency, result, optional backpressure, handshake
  task automatic run_op(input string tag, input logic [30:0] a, input logic [15:0] b,
                        input int hold);
    logic [15:0] eq, er;
    logic        eo, ed;
    int          n;
    model(a, b, eq, er, eo, ed);
    wait_ready(tag);
    din0     = a;
    din1     = b;
    in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    din0     = 31'($urandom);
    din1     = 16'($urandom);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge ap_clk); #1;
      n++;
    end
    check({tag, ":lat"},  32'(n),   32'd32);
    check({tag, ":dout"}, 32'(dout), 32'(eq));
    check({tag, ":rem"},  32'(rem),  32'(er));
    check({tag, ":ovf"},  32'(ovf),  32'(eo));
    check({tag, ":dbz"},  32'(dbz),  32'(ed));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      din0     = 31'($urandom);
      din1     = 16'($urandom);
      @(posedge ap_clk); #1;
      check({tag, ":bp_inrdy"}, 32'(in_ready),  32'd0);
      check({tag, ":bp_ov"},    32'(out_valid), 32'd1);
      check({tag, ":bp_dout"},  32'(dout),      32'(eq));
      check({tag, ":bp_rem"},   32'(rem),       32'(er));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
    check({tag, ":post_ov"}, 32'(out_valid), 32'd0);
    check({tag, ":post_ir"}, 32'(in_ready),  32'd1);
  endtask

  initial begin
    logic [30:0] ra;
    logic [15:0] rb;
    int          n;

    // Reset state
    #12;
    check("rst:in_ready",  32'(in_ready),  32'd1);
    check("rst:out_valid", 32'(out_valid), 32'd0);
    check("rst:dout",      32'(dout),      32'd0);
    check("rst:rem",       32'(rem),       32'd0);
    check("rst:ovf",       32'(ovf),       32'd0);
    check("rst:dbz",       32'(dbz),       32'd0);
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    // Directed cases
    run_op("basic",    31'd1000,               16'd7,        0);
    run_op("neg_a",    -31'sd1000,             16'd7,        0);
    run_op("neg_b",    31'd1000,               -16'sd7,      0);
    run_op("neg_ab",   -31'sd1000,             -16'sd7,      0);
    run_op("min_m1",   31'h4000_0000,          16'hFFFF,     0);
    run_op("big_p1",   31'd1048576,            16'd1,        0);
    run_op("qmin",     -31'sd65536,            16'd2,        0);
    run_op("dbz_neg",  -31'sd5,                16'd0,        0);
    run_op("dbz_pos",  31'd5,                  16'd0,        0);
    run_op("div_min",  31'h4000_0000,          16'h8000,     0);
    run_op("bp",       31'd123456,             16'd789,      10);
    run_op("after_bp", 31'd77,                 -16'sd5,      0);

    // Reset in the middle of CALC aborts the operation immediately
    wait_ready("rstmid");
    din0     = 31'd999999;
    din1     = 16'd3;
    in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    repeat (15) begin
      @(posedge ap_clk); #1;
    end
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("rstmid:out_valid", 32'(out_valid), 32'd0);
    check("rstmid:in_ready",  32'(in_ready),  32'd1);
    check("rstmid:dout",      32'(dout),      32'd0);
    @(posedge ap_clk); #3;
    ap_rst_n = 1'b1;
    // No result may appear after the aborted operation
    n = 0;
    repeat (40) begin
      @(posedge ap_clk); #1;
      if (out_valid) n++;
    end
    check("rstmid:no_out", 32'(n), 32'd0);
    run_op("rst_100_10", 31'd100, 16'd10, 0);

    // Randomized operands
    for (int i = 0; i < 24; i++) begin
      ra = 31'($urandom);
      case (i % 4)
        0: rb = 16'($urandom);
        1: rb = 16'($urandom_range(1, 300));
        2: rb = -16'($urandom_range(1, 300));
        default: begin
          rb = 16'($urandom);
          ra = 31'($signed(rb)) * 31'($urandom_range(0, 40000)) + 31'($urandom_range(0, 50));
        end
      endcase
      if (i == 13) rb = 16'd0;
      run_op("rand", ra, rb, (i == 5) ? 3 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
